// File: rtl/commit_pkg.sv
// ----------------------------------------------------------------------------
// commit_pkg : opcode/register constants and FSM states for ROB retirement
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package commit_pkg;
   localparam logic [4:0] OP_ALU  = 5'b00000;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_LW   = 5'b01000;
   localparam logic [4:0] OP_SW   = 5'b00111;
   localparam logic [4:0] OP_JAL  = 5'b00011;
   localparam logic [4:0] OP_SETX = 5'b10101;

   localparam logic [4:0] R30 = 5'd30;
   localparam logic [4:0] R31 = 5'd31;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_SWAIT = 1'b1
   } state_t;
endpackage

`default_nettype wire

// File: rtl/commit_decode.sv
// ----------------------------------------------------------------------------
// commit_decode : classifies the retiring instruction (write/store/destination)
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module commit_decode
   import commit_pkg::*;
(
   input  logic [31:0] i_instr,
   output logic        o_writes,
   output logic        o_is_store,
   output logic [4:0]  o_dest
);
   logic [4:0] w_op;
   logic [4:0] w_rd;

   assign w_op = i_instr[31:27];
   assign w_rd = i_instr[26:22];

   always_comb begin
      o_writes   = 1'b0;
      o_is_store = 1'b0;
      o_dest     = 5'd0;
      case (w_op)
         OP_ALU, OP_ADDI, OP_LW: begin
            o_writes = 1'b1;
            o_dest   = w_rd;
         end
         OP_JAL: begin
            o_writes = 1'b1;
            o_dest   = R31;
         end
         OP_SETX: begin
            o_writes = 1'b1;
            o_dest   = R30;
         end
         OP_SW:   o_is_store = 1'b1;
         default: ;
      endcase
   end
endmodule

`default_nettype wire

// File: rtl/rob_commit_unit.sv
// ----------------------------------------------------------------------------
// rob_commit_unit : in-order ROB retirement, regfile write port, store handshake
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rob_commit_unit
   import commit_pkg::*;
#(
   parameter bit ALLOW_R0_WRITE = 1'b0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] head_instr,
   input  logic [31:0] head_val,
   input  logic        head_ready,
   input  logic        is_empty,
   output logic        pop,
   output logic        ctrl_writeEnable,
   output logic [4:0]  ctrl_writeReg,
   output logic [31:0] data_writeReg,
   output logic        store_commit,
   input  logic        store_ack,
   input  logic        hold,
   output logic [31:0] retired_count
);
   state_t      r_state;
   logic        r_we;
   logic [4:0]  r_wreg;
   logic [31:0] r_wdata;
   logic        r_store_commit;
   logic [31:0] r_count;

   logic        w_writes;
   logic        w_is_store;
   logic [4:0]  w_dest;
   logic        w_valid;
   logic        w_pop;
   logic        w_dest_ok;

   commit_decode u_decode (
      .i_instr    (head_instr),
      .o_writes   (w_writes),
      .o_is_store (w_is_store),
      .o_dest     (w_dest)
   );

   assign w_valid   = !is_empty && (|head_instr) && head_ready;
   assign w_dest_ok = (w_dest != 5'd0) || ALLOW_R0_WRITE;

   // In SWAIT the store is popped only together with the buffer's ack; hold is ignored there.
   always_comb begin
      w_pop = 1'b0;
      if (!reset && w_valid) begin
         if (r_state == ST_RUN)
            w_pop = !hold && !w_is_store;
         else
            w_pop = store_ack;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= ST_RUN;
         r_we           <= 1'b0;
         r_wreg         <= 5'd0;
         r_wdata        <= 32'd0;
         r_store_commit <= 1'b0;
         r_count        <= 32'd0;
      end else begin
         r_we <= 1'b0;
         if (w_pop)
            r_count <= r_count + 32'd1;
         case (r_state)
            ST_RUN: begin
               if (w_pop) begin
                  r_we    <= w_writes && w_dest_ok;
                  r_wreg  <= w_dest;
                  r_wdata <= head_val;
               end else if (w_valid && !hold && w_is_store) begin
                  r_store_commit <= 1'b1;
                  r_state        <= ST_SWAIT;
               end
            end
            ST_SWAIT: begin
               if (w_pop) begin
                  r_store_commit <= 1'b0;
                  r_state        <= ST_RUN;
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   assign pop              = w_pop;
   assign ctrl_writeEnable = r_we;
   assign ctrl_writeReg    = r_wreg;
   assign data_writeReg    = r_wdata;
   assign store_commit     = r_store_commit;
   assign retired_count    = r_count;
endmodule

`default_nettype wire
